hazard_scoreboard: RTL and testbench

// - Tracks outstanding register writes for in-flight uops; flags RAW/WAW hazards for the uop in decode.
// - Sits beside the decode stage: decode queries with rs1/rs2/rd, ORs hazard into its downstream stall,

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_counter.sv | 47 ++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared uop definitions: architectural register count and register index type.
// Every block that touches register indices imports these definitions.
package hazard_scoreboard_pkg;

    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = $clog2(NUM_REGS);

    typedef logic [REG_IDX_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = reg_idx_t'(0);

    // A register reference only matters when it is used and is not the hard-wired zero register.
    function automatic logic isLiveRef(input logic used, input reg_idx_t idx);
        return used && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Per-register in-flight write counter (sb_counter): saturating up/down with a clear.
// Simultaneous inc and dec leave the count unchanged.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] countNext,
    output logic             zero,
    output logic             full
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Next-count selection; clear wins over any traffic in the same cycle.
    always_comb begin
        countNext = count;
        if (clr) begin
            countNext = CNT_ZERO;
        end else if (inc && !dec && (count != CNT_MAX)) begin
            countNext = count + CNT_ONE;
        end else if (dec && !inc && (count != CNT_ZERO)) begin
            countNext = count - CNT_ONE;
        end else begin
            countNext = count;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= CNT_ZERO;
        end else begin
            count <= countNext;
        end
    end

    assign zero = (count == CNT_ZERO);
    assign full = (count == CNT_MAX);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side scoreboard: counts outstanding register writes and flags RAW/WAW hazards
// for the uop currently in decode.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int CNT_W     = 2,
    parameter int WB_BYPASS = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  reg_idx_t qRs1,
    input  logic     qRs1Used,
    input  reg_idx_t qRs2,
    input  logic     qRs2Used,
    input  reg_idx_t qRd,
    input  logic     qRdUsed,
    output logic     hazard,
    input  logic     issueFire,
    input  logic     wbValid,
    input  reg_idx_t wbRd,
    input  logic     flush,
    output logic     idle,
    output logic     underflow
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]    cnt [NUM_REGS];
    logic [NUM_REGS-1:0] zeroVec;
    logic [NUM_REGS-1:0] fullVec;
    logic [NUM_REGS-1:0] nextZeroVec;

    logic rs1Haz;
    logic rs2Haz;
    logic rdSat;

    assign cnt[0]         = CNT_ZERO;
    assign zeroVec[0]     = 1'b1;
    assign fullVec[0]     = 1'b0;
    assign nextZeroVec[0] = 1'b1;

    for (genvar r = 1; r < NUM_REGS; r++) begin : gCnt
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] nxt;

        assign inc = issueFire && qRdUsed && (qRd == reg_idx_t'(r));
        assign dec = wbValid && (wbRd == reg_idx_t'(r)) && !zeroVec[r];

        sb_counter #(.CNT_W(CNT_W)) uCnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc),
            .dec       (dec),
            .clr       (flush),
            .count     (cnt[r]),
            .countNext (nxt),
            .zero      (zeroVec[r]),
            .full      (fullVec[r])
        );

        assign nextZeroVec[r] = (nxt == CNT_ZERO);
    end

    // A writeback retiring the last outstanding write satisfies the source in the same cycle.
    function automatic logic srcHaz(input logic used, input reg_idx_t s,
                                    input logic [CNT_W-1:0] c, input logic isZero);
        logic bypass;
        bypass = (WB_BYPASS != 0) && wbValid && (wbRd == s) && (c == CNT_ONE);
        return isLiveRef(used, s) && !isZero && !bypass;
    endfunction

    // Hazard lookup: source RAW checks plus destination counter saturation.
    always_comb begin
        rs1Haz = srcHaz(qRs1Used, qRs1, cnt[qRs1], zeroVec[qRs1]);
        rs2Haz = srcHaz(qRs2Used, qRs2, cnt[qRs2], zeroVec[qRs2]);
        rdSat  = isLiveRef(qRdUsed, qRd) && fullVec[qRd];
        hazard = rs1Haz || rs2Haz || rdSat;
    end

    // Idle reflects the counters as they will be after this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle <= 1'b1;
        end else begin
            idle <= &nextZeroVec;
        end
    end

    // Sticky underflow; a flush cycle discards its writeback, so it cannot set the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else if (!flush && wbValid && (wbRd != REG_ZERO) && zeroVec[wbRd]) begin
            underflow <= 1'b1;
        end else begin
            underflow <= underflow;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard: directed vector table, a reset sequence,
// then randomized traffic against a counting reference model.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] qRs1, qRs2, qRd, wbRd;
    logic       qRs1Used, qRs2Used, qRdUsed;
    logic       issueFire, wbValid, flush;
    logic       hazard, idle, underflow;

    int passCnt  = 0;
    int checkCnt = 0;

    localparam int MAXC = 3;
    int  mc [32];
    bit  mUf;

    hazard_scoreboard #(.CNT_W(2), .WB_BYPASS(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .qRs1      (qRs1),
        .qRs1Used  (qRs1Used),
        .qRs2      (qRs2),
        .qRs2Used  (qRs2Used),
        .qRd       (qRd),
        .qRdUsed   (qRdUsed),
        .hazard    (hazard),
        .issueFire (issueFire),
        .wbValid   (wbValid),
        .wbRd      (wbRd),
        .flush     (flush),
        .idle      (idle),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1; logic rs1u;
        logic [4:0] rs2; logic rs2u;
        logic [4:0] rd;  logic rdu;
        logic iss; logic wbv; logic [4:0] wbrd; logic fl;
        logic eHaz; logic eIdle; logic eUf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic act, input logic exp);
        checkCnt++;
        if (act !== exp) $display("FAIL %s: got %b expected %b", name, act, exp);
        else passCnt++;
    endtask

    function automatic vec_t mk(int rs1, int rs1u, int rs2, int rs2u, int rd, int rdu,
                                int iss, int wbv, int wbrd, int fl, int eh, int ei, int eu);
        vec_t v;
        v.rs1 = 5'(rs1); v.rs1u = 1'(rs1u); v.rs2 = 5'(rs2); v.rs2u = 1'(rs2u);
        v.rd = 5'(rd); v.rdu = 1'(rdu); v.iss = 1'(iss); v.wbv = 1'(wbv);
        v.wbrd = 5'(wbrd); v.fl = 1'(fl);
        v.eHaz = 1'(eh); v.eIdle = 1'(ei); v.eUf = 1'(eu);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        qRs1 = v.rs1; qRs1Used = v.rs1u; qRs2 = v.rs2; qRs2Used = v.rs2u;
        qRd = v.rd; qRdUsed = v.rdu; issueFire = v.iss; wbValid = v.wbv;
        wbRd = v.wbrd; flush = v.fl;
    endtask

    function automatic bit modelSrc(logic used, logic [4:0] s);
        int c;
        c = mc[s];
        if (!used || s == 5'd0 || c == 0) return 1'b0;
        if (wbValid && wbRd == s && c == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit modelHaz();
        bit sat;
        sat = qRdUsed && qRd != 5'd0 && mc[qRd] == MAXC;
        return modelSrc(qRs1Used, qRs1) || modelSrc(qRs2Used, qRs2) || sat;
    endfunction

    // Reference update: counts are integers, applied from the architectural rules.
    task automatic modelEdge();
        bit decOk;
        if (rst) begin
            foreach (mc[i]) mc[i] = 0;
            mUf = 1'b0;
        end else if (flush) begin
            foreach (mc[i]) mc[i] = 0;
        end else begin
            decOk = wbValid && wbRd != 5'd0 && mc[wbRd] != 0;
            if (wbValid && wbRd != 5'd0 && mc[wbRd] == 0) mUf = 1'b1;
            if (issueFire && qRdUsed && qRd != 5'd0) mc[qRd] = mc[qRd] + 1;
            if (decOk) mc[wbRd] = mc[wbRd] - 1;
        end
    endtask

    function automatic bit modelIdle();
        foreach (mc[i]) if (mc[i] != 0) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        rst = 1'b1;
        drive(mk(0,0,0,0,0,0, 0,0,0,0, 0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.idle", idle, 1'b1);
        chk("reset.underflow", underflow, 1'b0);

        tbl.push_back(mk(5,1,6,1,7,1, 0,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,3,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(3,1,0,0,0,0, 0,0,0,0, 1,0,0));
        tbl.push_back(mk(3,1,0,0,0,0, 0,1,3,0, 0,1,0));
        tbl.push_back(mk(3,1,0,0,0,0, 0,0,0,0, 0,1,0));
        for (int k = 0; k < 3; k++) tbl.push_back(mk(0,0,0,0,4,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,4,1, 0,0,0,0, 1,0,0));
        tbl.push_back(mk(0,0,0,0,4,1, 0,1,4,0, 1,0,0));
        tbl.push_back(mk(0,0,0,0,4,1, 0,0,0,0, 0,0,0));
        tbl.push_back(mk(4,1,0,0,0,0, 0,1,4,0, 1,0,0));
        tbl.push_back(mk(0,0,4,1,0,0, 0,1,4,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,9,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,9,1, 1,1,9,0, 0,0,0));
        tbl.push_back(mk(9,1,0,0,0,0, 0,0,0,0, 1,0,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,9,0, 0,1,0));
        tbl.push_back(mk(0,1,0,1,0,1, 1,0,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0, 0,1,0,0, 0,1,0));
        tbl.push_back(mk(0,0,0,0,2,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(0,0,0,0,5,1, 1,0,0,0, 0,0,0));
        tbl.push_back(mk(2,1,5,1,8,1, 1,0,0,1, 1,1,0));
        tbl.push_back(mk(2,1,0,0,0,0, 0,1,2,0, 0,1,1));
        tbl.push_back(mk(5,1,0,0,0,0, 0,0,0,0, 0,1,1));
        tbl.push_back(mk(0,0,0,0,1,1, 1,0,0,0, 0,0,1));
        tbl.push_back(mk(1,1,0,0,0,0, 0,0,0,0, 1,0,1));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            #1;
            chk($sformatf("vec%0d.hazard", i), hazard, tbl[i].eHaz);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.idle", i), idle, tbl[i].eIdle);
            chk($sformatf("vec%0d.underflow", i), underflow, tbl[i].eUf);
            @(negedge clk);
        end

        // Mid-operation reset: reg 1 still outstanding, sticky underflow set.
        drive(mk(1,1,0,0,0,0, 0,0,0,0, 0,0,0));
        rst = 1'b1;
        #1;
        chk("midRst.hazardBeforeEdge", hazard, 1'b1);
        @(posedge clk);
        #1;
        chk("midRst.idle", idle, 1'b1);
        chk("midRst.underflow", underflow, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midRst.hazardAfter", hazard, 1'b0);

        // Randomized traffic on a small register window to force collisions.
        foreach (mc[i]) mc[i] = 0;
        mUf = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 24) == 0);
            qRs1 = 5'($urandom_range(0, 7)); qRs1Used = 1'($urandom_range(0, 1));
            qRs2 = 5'($urandom_range(0, 7)); qRs2Used = 1'($urandom_range(0, 1));
            qRd  = 5'($urandom_range(0, 7)); qRdUsed  = 1'($urandom_range(0, 3) != 0);
            issueFire = ($urandom_range(0, 1) == 1) && !(qRdUsed && qRd != 5'd0 && mc[qRd] == MAXC);
            wbRd = 5'($urandom_range(0, 7));
            if (flush) wbValid = 1'b0;
            else if (mc[wbRd] != 0) wbValid = ($urandom_range(0, 2) != 0);
            else wbValid = ($urandom_range(0, 39) == 0);
            #1;
            chk($sformatf("rnd%0d.hazard", n), hazard, modelHaz());
            @(posedge clk);
            modelEdge();
            #1;
            chk($sformatf("rnd%0d.idle", n), idle, modelIdle());
            chk($sformatf("rnd%0d.underflow", n), underflow, mUf);
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
